tcm_dec_trb_traceback: RTL and testbench

TCM_DEC_TRB_TRACEBACK -- requirements
Module: tcm_dec_trb_traceback

---
 rtl/tcm_dec_trb_traceback.sv | 228 ++++++++++++++++++++++
 tb/tb_tcm_dec_trb_traceback.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tcm_dec_trb_traceback.sv
// -----------------------------------------------------------------------------
// tcm_dec_trb_traceback
//   Viterbi survivor-memory traceback for the TCM decoder.
//
//   Decisions are written into a 4-bank circular survivor RAM. Each time a
//   bank completes (except the first after reset), a traceback starts. It
//   trains over the newest bank and then decodes the bank before it into
//   one pTB_LEN-bit word. Bit 0 of that word is the oldest symbol.
//
//   Optional feature: define TCM_DEC_TRB_BEST_STATE_EN to start the traceback
//   from the latched best state istate. Without it, traceback starts from
//   state 0 and the training pass alone provides convergence.
//
// Ports
//   iclk        clock, rising edge
//   ireset      asynchronous active-low reset
//   iclkena     clock enable, gates every register
//   idec_val    decision vector valid (from ACS)
//   idec        per-state predecessor select bits
//   istate_val  best-state valid from decision tree (not needed here)
//   istate      best-state index
//   oval        one-cycle pulse: odat holds a newly decoded bank
//   odat        decoded bits; held until the next oval
//   oerr        pulse: a bank completed while a traceback was still running
// -----------------------------------------------------------------------------
module tcm_dec_trb_traceback #(
  parameter int pCONSTR_LENGTH = 7,
  parameter int pTB_LEN        = 32
) (
  input  logic                              iclk,
  input  logic                              ireset,
  input  logic                              iclkena,
  input  logic                              idec_val,
  input  logic [2**(pCONSTR_LENGTH-1)-1:0]  idec,
  input  logic                              istate_val,
  input  logic [pCONSTR_LENGTH-2:0]         istate,
  output logic                              oval,
  output logic [pTB_LEN-1:0]                odat,
  output logic                              oerr
);

  localparam int cSTATE_NUM  = 2**(pCONSTR_LENGTH-1);
  localparam int cTREE_DEPTH = pCONSTR_LENGTH-1;
  localparam int cOFF_W      = $clog2(pTB_LEN);
  localparam logic [cOFF_W-1:0] cLAST = cOFF_W'(pTB_LEN-1);

  typedef enum logic [1:0] {IDLE, TRAIN, DECODE, DONE} state_t;

  // Delay line: this aligns each decision word with the decision-tree output.
  logic [cTREE_DEPTH-1:0] dval_q;
  logic [cSTATE_NUM-1:0]  ddec_q [cTREE_DEPTH];

  always_ff @(posedge iclk or negedge ireset)
    if (!ireset)      dval_q <= '0;
    else if (iclkena) dval_q <= {dval_q[cTREE_DEPTH-2:0], idec_val};

  always_ff @(posedge iclk)
    if (iclkena) begin
      ddec_q[0] <= idec;
      for (int i = 1; i < cTREE_DEPTH; i++) ddec_q[i] <= ddec_q[i-1];
    end

  logic                  wr_val;
  logic [cSTATE_NUM-1:0] wr_dec;
  assign wr_val = dval_q[cTREE_DEPTH-1];
  assign wr_dec = ddec_q[cTREE_DEPTH-1];

  // Write pointer and start request.
  logic [cOFF_W-1:0] wr_off_q;
  logic [1:0]        wr_bank_q;
  logic              bank_done_q;    // at least one bank completed since reset
  logic              wr_last, start_req, busy, accept;

  assign wr_last   = wr_val && (wr_off_q == cLAST);
  assign start_req = iclkena && wr_last && bank_done_q;

  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) begin
      wr_off_q    <= '0;
      wr_bank_q   <= '0;
      bank_done_q <= 1'b0;
    end else if (iclkena && wr_val) begin
      wr_off_q <= wr_off_q + 1'b1;
      if (wr_last) begin
        wr_bank_q   <= wr_bank_q + 1'b1;
        bank_done_q <= 1'b1;
      end
    end

  // Start state (optional best-state feature).
  logic [cTREE_DEPTH-1:0] start_st;
  logic                   unused_ok;
`ifdef TCM_DEC_TRB_BEST_STATE_EN
  assign start_st  = istate;
  assign unused_ok = &{1'b0, istate_val};
`else
  assign start_st  = '0;
  assign unused_ok = &{1'b0, istate_val, istate};
`endif

  // FSM.
  // DONE issues the final decode read (offset 0). This makes the read stream
  // back-to-back at 50% duty, so a new start can be taken in DONE.
  state_t            state_q, state_d;
  logic [cOFF_W-1:0] cnt_q, cnt_d;
  logic [1:0]        tb_bank_q, rd_bank;
  logic [cTREE_DEPTH-1:0] start_st_q;
  logic              rd_en, rd_dec;

  assign busy   = (state_q == TRAIN) || (state_q == DECODE);
  assign accept = start_req && !busy;
  assign oerr   = start_req && busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_dec  = 1'b0;
    rd_bank = tb_bank_q;
    case (state_q)
      IDLE: ;
      TRAIN: begin
        rd_en = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DECODE;
          cnt_d   = cLAST;
        end
      end
      DECODE: begin
        rd_en   = 1'b1;
        rd_dec  = 1'b1;
        rd_bank = tb_bank_q - 2'd1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == cOFF_W'(1)) state_d = DONE;
      end
      DONE: begin
        rd_en   = 1'b1;
        rd_dec  = 1'b1;
        rd_bank = tb_bank_q - 2'd1;
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      state_d = TRAIN;
      cnt_d   = cLAST;
    end
  end

  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tb_bank_q  <= '0;
      start_st_q <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        tb_bank_q  <= wr_bank_q;
        start_st_q <= start_st;
      end
    end

  // Survivor RAM: 4 banks, 1-cycle read latency.
  logic [cSTATE_NUM-1:0] ram_q [4*pTB_LEN];
  logic [cSTATE_NUM-1:0] rdat_q;

  always_ff @(posedge iclk)
    if (iclkena) begin
      if (wr_val) ram_q[{wr_bank_q, wr_off_q}] <= wr_dec;
      if (rd_en)  rdat_q <= ram_q[{rd_bank, cnt_q}];
    end

  // Return-side tags that travel alongside the read data.
  logic              ret_vld_q, ret_last_q, ret_dec_q, ret_first_q;
  logic [cOFF_W-1:0] ret_off_q;

  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) begin
      ret_vld_q   <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_dec_q   <= 1'b0;
      ret_first_q <= 1'b0;
      ret_off_q   <= '0;
    end else if (iclkena) begin
      ret_vld_q   <= rd_en;
      ret_last_q  <= (state_q == DONE);
      ret_dec_q   <= rd_dec;
      ret_first_q <= (state_q == TRAIN) && (cnt_q == cLAST);
      ret_off_q   <= cnt_q;
    end

  // Traceback datapath. The start state is applied when the first word returns,
  // so the previous traceback can still finish its last word.
  logic [cTREE_DEPTH-1:0] s_q, s_cur, s_nxt;
  logic [pTB_LEN-1:0]     buf_q, buf_nxt;

  assign s_cur = ret_first_q ? start_st_q : s_q;
  assign s_nxt = {s_cur[cTREE_DEPTH-2:0], rdat_q[s_cur]};

  always_comb begin
    buf_nxt = buf_q;
    if (ret_vld_q && ret_dec_q) buf_nxt[ret_off_q] = s_cur[cTREE_DEPTH-1];
  end

  always_ff @(posedge iclk)
    if (iclkena && ret_vld_q) begin
      s_q   <= s_nxt;
      buf_q <= buf_nxt;
    end

  logic               oval_q;
  logic [pTB_LEN-1:0] odat_q;

  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) begin
      oval_q <= 1'b0;
      odat_q <= '0;
    end else if (iclkena) begin
      oval_q <= ret_vld_q && ret_last_q;
      if (ret_vld_q && ret_last_q) odat_q <= buf_nxt;
    end

  assign oval = oval_q;
  assign odat = odat_q;

endmodule

// File: tb/tb_tcm_dec_trb_traceback.sv
// -----------------------------------------------------------------------------
// tb_tcm_dec_trb_traceback
//   Directed bench for tcm_dec_trb_traceback (default build, K=7, TB_LEN=32).
//   The decisions come from a reference encoder. At time n, every state's
//   predecessor bit equals the input bit that just left the encoder register
//   (u[n-6]). A traceback from any state therefore merges onto the true path
//   within 6 steps, and the decoded word equals the transmitted bits.
// -----------------------------------------------------------------------------
module tb_tcm_dec_trb_traceback;

  localparam int NS = 64;
  localparam int D  = 6;
  localparam int L  = 32;

  logic          iclk = 1'b0;
  logic          ireset, iclkena, idec_val, istate_val;
  logic [NS-1:0] idec;
  logic [D-1:0]  istate;
  logic          oval, oerr;
  logic [L-1:0]  odat;

  always #5 iclk = ~iclk;

  tcm_dec_trb_traceback #(.pCONSTR_LENGTH(7), .pTB_LEN(L)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .idec_val(idec_val), .idec(idec),
    .istate_val(istate_val), .istate(istate),
    .oval(oval), .odat(odat), .oerr(oerr)
  );

  int checks = 0, errors = 0;

  // Enabled-cycle counter and output monitor (only enabled cycles count).
  int          ecyc = 0;
  int          ov_cnt = 0, oerr_cnt = 0;
  int          ov_cyc [32];
  logic [31:0] ov_dat [32];

  always @(posedge iclk) if (iclkena === 1'b1) ecyc <= ecyc + 1;

  always @(negedge iclk)
    if (iclkena === 1'b1) begin
      if (oval === 1'b1) begin
        if (ov_cnt < 32) begin
          ov_cyc[ov_cnt] = ecyc;
          ov_dat[ov_cnt] = odat;
        end
        ov_cnt++;
      end
      if (oerr === 1'b1) oerr_cnt++;
    end

  // Stimulus state.
  int          mode = 0;       // 0: all-zero, 1: 1010..., 2: per-bank patterns
  logic [31:0] pat [5];
  bit          en_rand = 0;
  int          sym_cyc = 0;    // enabled-cycle index of the last captured symbol
  int          b, e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ubit(input int i);
    case (mode)
      1:       return (i % 2 == 0);
      2:       return pat[i/32][i%32];
      default: return 1'b0;
    endcase
  endfunction

  // One enabled cycle. With en_rand set, disabled cycles are inserted before
  // it while the inputs are held.
  task automatic tick(input logic v, input logic [NS-1:0] d);
    int dis = 0;
    do begin
      iclkena    = (en_rand && dis < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      idec_val   = v;
      istate_val = v;
      idec       = d;
      istate     = 6'($urandom);
      if (iclkena && v) sym_cyc = ecyc;
      dis++;
      @(posedge iclk); #1;
    end while (!iclkena);
  endtask

  task automatic send(input int first, input int nsym, input int gap);
    for (int n = first; n < first + nsym; n++) begin
      tick(1'b1, (n < 6) ? {NS{1'b0}} : {NS{ubit(n-6)}});
      repeat (gap) tick(1'b0, '0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0);
  endtask

  task automatic do_reset();
    iclkena  = 1'b1;
    idec_val = 1'b0;
    ireset   = 1'b0;
    repeat (2) begin @(posedge iclk); #1; end
    ireset = 1'b1;
    @(posedge iclk); #1;
  endtask

  initial begin
    pat[0] = 32'hDEADBEEF; pat[1] = 32'h12345678; pat[2] = 32'hCAFEF00D;
    pat[3] = 32'h0F1E2D3C; pat[4] = 32'hA5C3961E;
    ireset = 1'b0; iclkena = 1'b1; idec_val = 1'b0; istate_val = 1'b0;
    idec = '0; istate = '0;
    repeat (3) begin @(posedge iclk); #1; end
    chk("reset_oval", 64'(oval), 64'd0);
    chk("reset_oerr", 64'(oerr), 64'd0);
    chk("reset_odat", 64'(odat), 64'd0);
    ireset = 1'b1;
    @(posedge iclk); #1;

    // All-zero decisions, 50% duty, 64 symbols.
    mode = 0; b = ov_cnt; e = oerr_cnt;
    send(0, 64, 1); idle(100);
    chk("zero_count", 64'(ov_cnt - b), 64'd1);
    chk("zero_odat",  64'(ov_dat[b]), 64'd0);
    chk("zero_lat",   64'(ov_cyc[b] - sym_cyc), 64'd72);
    chk("zero_oerr",  64'(oerr_cnt - e), 64'd0);

    // 1010... stream, 128 symbols at 50% duty.
    do_reset(); mode = 1; b = ov_cnt; e = oerr_cnt;
    send(0, 128, 1); idle(100);
    chk("alt_count", 64'(ov_cnt - b), 64'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("alt_odat%0d", i), 64'(ov_dat[b+i]), 64'h55555555);
    chk("alt_lat",     64'(ov_cyc[b+2] - sym_cyc), 64'd72);
    chk("alt_spacing", 64'(ov_cyc[b+1] - ov_cyc[b]), 64'd64);
    chk("alt_oerr",    64'(oerr_cnt - e), 64'd0);

    // Full rate, 160 symbols: every other start overruns.
    do_reset(); mode = 2; b = ov_cnt; e = oerr_cnt;
    send(0, 160, 0); idle(150);
    chk("full_count", 64'(ov_cnt - b), 64'd2);
    chk("full_odat0", 64'(ov_dat[b]),   64'(pat[0]));
    chk("full_odat1", 64'(ov_dat[b+1]), 64'(pat[2]));
    chk("full_oerr",  64'(oerr_cnt - e), 64'd2);

    // Reset 10 cycles into TRAIN aborts; 64 fresh symbols are then needed.
    do_reset(); mode = 1; b = ov_cnt;
    send(0, 64, 1); idle(15);
    do_reset(); idle(100);
    chk("rst_abort", 64'(ov_cnt - b), 64'd0);
    send(0, 63, 1); idle(150);
    chk("rst_63sym", 64'(ov_cnt - b), 64'd0);
    send(63, 1, 1); idle(100);
    chk("rst_64sym", 64'(ov_cnt - b), 64'd1);
    chk("rst_odat",  64'(ov_dat[b]), 64'h55555555);

    // Random istate and random clock enable.
    do_reset(); en_rand = 1; mode = 1; b = ov_cnt; e = oerr_cnt;
    send(0, 128, 1); idle(100);
    en_rand = 0; iclkena = 1'b1;
    chk("ena_count", 64'(ov_cnt - b), 64'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("ena_odat%0d", i), 64'(ov_dat[b+i]), 64'h55555555);
    chk("ena_lat",  64'(ov_cyc[b+2] - sym_cyc), 64'd72);
    chk("ena_oerr", 64'(oerr_cnt - e), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
